// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART constants for uart_rx, uart_tx and uart_rx_fifo.
//   UART_DATA_W     : byte width carried between the UART blocks
//   UART_FIFO_DEPTH : default receive/transmit buffer depth
//   UART_FIFO_CW    : pointer/count width for the default depth
//   ptr_width()     : pointer/count width for any power-of-two depth; the
//                     extra MSB tells a full buffer apart from an empty one
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int UART_FIFO_CW = ptr_width(UART_FIFO_DEPTH);

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// -----------------------------------------------------------------------------
// uart_fifo_mem
// DEPTH x WIDTH storage array for the UART buffers: one registered write port
// and one asynchronous (combinational) read port.
// Ports:
//   clk_i      : clock
//   wr_en_i    : write strobe, already qualified by the FIFO control logic
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_addr_i  : read address
//   rd_data_o  : mem[rd_addr_i], combinational
// -----------------------------------------------------------------------------
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset; contents are only ever read behind a valid
  // pointer, so clearing them would buy nothing and would block RAM mapping.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      r_mem[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = r_mem[rd_addr_i];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Show-ahead receive buffer placed behind uart_rx. Every accepted rx_valid_i
// strobe stores one byte; the bus side pops bytes with rd_req_i and sees level,
// sticky overflow and interrupt status.
//
// Build option: define UART_RX_FIFO_TIMEOUT_EN to add a 16-bit idle counter
// that raises timeout_o when a non-empty buffer has seen neither a write nor
// a pop for timeout_i cycles. Without it timeout_o is tied low and timeout_i is
// ignored; the port list is the same in both builds.
//
// Ports (CW = $clog2(DEPTH)+1):
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   rx_data_i     : [WIDTH] byte from uart_rx
//   rx_valid_i    : write strobe from uart_rx
//   rd_req_i      : pop the head entry (ignored while empty)
//   rd_data_o     : [WIDTH] head entry, 0 while empty
//   empty_o       : buffer empty
//   full_o        : buffer full
//   count_o       : [CW] stored entries, 0..DEPTH
//   thresh_i      : [CW] interrupt level, 0 disables the level interrupt
//   overflow_o    : sticky, a byte was dropped
//   ovf_clr_i     : clears overflow_o (a new overflow in the same cycle wins)
//   timeout_i     : [16] idle timeout in cycles, 0 disables
//   timeout_o     : idle timeout flag
//   irq_o         : level || overflow || timeout
// -----------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int WIDTH = UART_DATA_W
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [WIDTH-1:0]              rx_data_i,
  input  logic                          rx_valid_i,
  input  logic                          rd_req_i,
  output logic [WIDTH-1:0]              rd_data_o,
  output logic                          empty_o,
  output logic                          full_o,
  output logic [ptr_width(DEPTH)-1:0]   count_o,
  input  logic [ptr_width(DEPTH)-1:0]   thresh_i,
  output logic                          overflow_o,
  input  logic                          ovf_clr_i,
  input  logic [15:0]                   timeout_i,
  output logic                          timeout_o,
  output logic                          irq_o
);

  localparam int CW = ptr_width(DEPTH);
  localparam int AW = CW - 1;

  logic [CW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_rd_ptr;
  logic             r_overflow;

  logic             w_empty;
  logic             w_full;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic             w_ovf_set;
  logic [WIDTH-1:0] w_mem_rd_data;

  // Pointers carry one extra MSB: equal pointers mean empty, equal low bits
  // with differing MSBs mean full.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[CW-1] != r_rd_ptr[CW-1]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop frees the slot in the same edge, so a write into a full buffer is
  // accepted when a pop accompanies it. A pop on an empty buffer never
  // happens, so write+pop while empty is a plain write.
  assign w_rd_acc  = rd_req_i && !w_empty;
  assign w_wr_acc  = rx_valid_i && (!w_full || rd_req_i);
  assign w_ovf_set = rx_valid_i && w_full && !rd_req_i;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours regardless of block ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_set) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr_i) begin
      r_overflow <= 1'b0;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk_i     (clk_i),
    .wr_en_i   (w_wr_acc),
    .wr_addr_i (r_wr_ptr[AW-1:0]),
    .wr_data_i (rx_data_i),
    .rd_addr_i (r_rd_ptr[AW-1:0]),
    .rd_data_o (w_mem_rd_data)
  );

`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [15:0] r_idle_cnt;
  logic        r_timeout;

  // Idle cycles since the last accepted write or pop; held at 0 while empty
  // so only a stalled, partially filled buffer can time out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_idle_cnt <= '0;
    end else if (w_wr_acc || w_rd_acc || w_empty) begin
      r_idle_cnt <= '0;
    end else if (r_idle_cnt != 16'hFFFF) begin
      r_idle_cnt <= r_idle_cnt + 16'd1;
    end
  end

  // Clearing wins over setting: a pop in the match cycle services the buffer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_timeout <= 1'b0;
    end else if (w_rd_acc || w_empty) begin
      r_timeout <= 1'b0;
    end else if ((timeout_i != 16'd0) && (r_idle_cnt == timeout_i)) begin
      r_timeout <= 1'b1;
    end
  end

  assign timeout_o = r_timeout;
`else
  // Idle detector not built; fold the unused input into a named sink.
  logic w_unused_timeout;
  assign w_unused_timeout = ^timeout_i;
  assign timeout_o        = 1'b0;
`endif

  assign empty_o    = w_empty;
  assign full_o     = w_full;
  assign count_o    = r_wr_ptr - r_rd_ptr;
  assign rd_data_o  = w_empty ? '0 : w_mem_rd_data;
  assign overflow_o = r_overflow;
  assign irq_o      = ((thresh_i != '0) && (count_o >= thresh_i)) ||
                      r_overflow || timeout_o;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Directed bench for uart_rx_fifo. Stimulus issues writes/pops and queues the
// byte each pop should return; a monitor on the falling edge compares rd_data_o
// against the queue whenever a pop is about to be accepted. Status outputs are
// checked 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int CW    = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] rx_data = '0;
  logic             rx_valid = 1'b0;
  logic             rd_req = 1'b0;
  logic [WIDTH-1:0] rd_data;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic [CW-1:0]    thresh = '0;
  logic             overflow;
  logic             ovf_clr = 1'b0;
  logic [15:0]      timeout_cfg = '0;
  logic             timeout;
  logic             irq;

  int tests = 0;
  int fails = 0;

  logic [WIDTH-1:0] sb [$];

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .rd_req_i   (rd_req),
    .rd_data_o  (rd_data),
    .empty_o    (empty),
    .full_o     (full),
    .count_o    (count),
    .thresh_i   (thresh),
    .overflow_o (overflow),
    .ovf_clr_i  (ovf_clr),
    .timeout_i  (timeout_cfg),
    .timeout_o  (timeout),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus, entered and left at posedge+1.
  task automatic step(input logic wr, input logic [7:0] d, input logic rd);
    rx_valid = wr;
    rx_data  = d;
    rd_req   = rd;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rd_req   = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    step(1'b1, d, 1'b0);
  endtask

  task automatic pop_exp(input logic [7:0] d);
    sb.push_back(d);
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  // Monitor: a pop will be accepted at the next edge, so rd_data_o now holds
  // the byte being consumed.
  always @(negedge clk) begin
    if (!rst && rd_req && !empty) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no pop at %0t", rd_data, $time);
      end else begin
        check("pop_data", 32'(rd_data), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state
    #12;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ---- basic write / show-ahead read
    push(8'h11);
    check("first_rd_data", 32'(rd_data), 32'h11);
    check("first_count", 32'(count), 32'd1);
    push(8'h22);
    push(8'h33);
    check("basic_count", 32'(count), 32'd3);
    check("basic_head", 32'(rd_data), 32'h11);
    pop_exp(8'h11);
    check("basic_head2", 32'(rd_data), 32'h22);
    pop_exp(8'h22);
    check("basic_head3", 32'(rd_data), 32'h33);
    pop_exp(8'h33);
    check("basic_empty", 32'(empty), 32'd1);
    check("basic_rd_zero", 32'(rd_data), 32'd0);

    // ---- fill, overflow, drain, clear
    for (int i = 0; i < 16; i++) push(8'(i));
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd16);
    check("fill_no_ovf", 32'(overflow), 32'd0);
    push(8'hAA);
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_irq", 32'(irq), 32'd1);
    for (int i = 0; i < 16; i++) pop_exp(8'(i));
    check("ovf_drained", 32'(empty), 32'd1);
    check("ovf_sticky", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);
    check("ovf_irq_clr", 32'(irq), 32'd0);

    // ---- write + pop while full
    for (int i = 0; i < 16; i++) push(8'(8'h30 + i));
    sb.push_back(8'h30);
    step(1'b1, 8'h55, 1'b1);
    check("wrrd_full_count", 32'(count), 32'd16);
    check("wrrd_full_ovf", 32'(overflow), 32'd0);
    check("wrrd_full_head", 32'(rd_data), 32'h31);
    for (int i = 1; i < 16; i++) pop_exp(8'(8'h30 + i));
    pop_exp(8'h55);
    check("wrrd_full_empty", 32'(empty), 32'd1);

    // ---- overflow set wins over a simultaneous clear
    for (int i = 0; i < 16; i++) push(8'(8'hC0 + i));
    ovf_clr = 1'b1;
    push(8'hEE);
    ovf_clr = 1'b0;
    check("ovf_set_priority", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) pop_exp(8'(8'hC0 + i));
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;

    // ---- write + pop while empty, pop while empty
    step(1'b1, 8'h77, 1'b1);
    check("wrrd_empty_count", 32'(count), 32'd1);
    check("wrrd_empty_head", 32'(rd_data), 32'h77);
    pop_exp(8'h77);
    step(1'b0, 8'h00, 1'b1);
    check("pop_empty_count", 32'(count), 32'd0);
    check("pop_empty_flag", 32'(empty), 32'd1);
    check("pop_empty_ovf", 32'(overflow), 32'd0);
    push(8'h88);
    check("after_pop_empty_count", 32'(count), 32'd1);
    check("after_pop_empty_head", 32'(rd_data), 32'h88);
    pop_exp(8'h88);

    // ---- threshold interrupt
    thresh = 5'd4;
    push(8'h41);
    push(8'h42);
    push(8'h43);
    check("thresh_below", 32'(irq), 32'd0);
    push(8'h44);
    check("thresh_reached", 32'(irq), 32'd1);
    pop_exp(8'h41);
    check("thresh_after_pop", 32'(irq), 32'd0);
    pop_exp(8'h42);
    pop_exp(8'h43);
    pop_exp(8'h44);
    thresh = '0;

    // ---- asynchronous reset mid-operation
    push(8'h61);
    push(8'h62);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_rd_data", 32'(rd_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

`ifdef UART_RX_FIFO_TIMEOUT_EN
    // ---- idle timeout: sets on the 101st edge after the write
    timeout_cfg = 16'd100;
    push(8'h99);
    idle(100);
    check("to_not_yet", 32'(timeout), 32'd0);
    idle(1);
    check("to_set", 32'(timeout), 32'd1);
    check("to_irq", 32'(irq), 32'd1);
    pop_exp(8'h99);
    check("to_clr_on_pop", 32'(timeout), 32'd0);

    // second write at cycle 50 restarts the count
    push(8'h9A);
    idle(49);
    push(8'h9B);
    idle(100);
    check("to_restart_not_yet", 32'(timeout), 32'd0);
    idle(1);
    check("to_restart_set", 32'(timeout), 32'd1);
    pop_exp(8'h9A);
    check("to_restart_clr", 32'(timeout), 32'd0);
    pop_exp(8'h9B);

    // disabled with timeout_i = 0
    timeout_cfg = 16'd0;
    push(8'h9C);
    idle(150);
    check("to_disabled", 32'(timeout), 32'd0);
    pop_exp(8'h9C);
`else
    // ---- idle detector absent: flag stays low regardless of timeout_i
    timeout_cfg = 16'd100;
    push(8'h99);
    idle(150);
    check("to_absent", 32'(timeout), 32'd0);
    check("to_absent_irq", 32'(irq), 32'd0);
    pop_exp(8'h99);
    timeout_cfg = 16'd0;
`endif

    idle(2);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("final_empty", 32'(empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_uart_rx_fifo
